// File: rtl/rk_ctrl_gen_pkg.sv
// rtl/rk_ctrl_gen_pkg.sv - shared types and constants for the RK8E-class controller
// Contents: sd link types (sdOP_t, sdSTATE_t, sdDISKaddr_t), controller FSM
// type (rkFSM_t), status bit indices, IOT function codes, command codes.
package sd_types;

    typedef enum logic [1:0] {
        sdopNOP,
        sdopRD,
        sdopWR,
        sdopABORT
    } sdOP_t;

    typedef enum logic [2:0] {
        sdstateINIT,
        sdstateREADY,
        sdstateREAD,
        sdstateWRITE,
        sdstateINFAIL,
        sdstateRWFAIL,
        sdstateDONE
    } sdSTATE_t;

    // {17 zero bits, drive[1:0], cylinder msb, dar[0:11]}
    typedef logic [0:31] sdDISKaddr_t;

    typedef enum logic [1:0] {
        rkIDLE,
        rkISSUE,
        rkXFER,
        rkABORT
    } rkFSM_t;

    // CPU major-state encoding of F1 (fetch phase in which IOTs execute)
    localparam logic [4:0] CPU_F1 = 5'd1;

    // Status register bit indices (bit 0 is the MSB, 0o4000)
    localparam int STAT_DONE  = 0;
    localparam int STAT_BUSY  = 5;
    localparam int STAT_WLOCK = 7;
    localparam int STAT_DRIVE = 10;
    localparam int STAT_CYL   = 11;

    // IOT function codes, instruction[9:11]
    localparam logic [2:0] FN_DSKP = 3'd1;
    localparam logic [2:0] FN_DCLC = 3'd2;
    localparam logic [2:0] FN_DLAG = 3'd3;
    localparam logic [2:0] FN_DLCA = 3'd4;
    localparam logic [2:0] FN_DRST = 3'd5;
    localparam logic [2:0] FN_DLDC = 3'd6;
    localparam logic [2:0] FN_DMAN = 3'd7;

    // Command register function field, cmd[0:2]
    localparam logic [0:2] CMD_READ     = 3'o0;
    localparam logic [0:2] CMD_READALL  = 3'o1;
    localparam logic [0:2] CMD_WPROT    = 3'o2;
    localparam logic [0:2] CMD_SEEK     = 3'o3;
    localparam logic [0:2] CMD_WRITE    = 3'o4;
    localparam logic [0:2] CMD_WRITEALL = 3'o5;

    // 000/001/100/101 move data; the middle bit is 0 for all of them
    function automatic logic cmd_is_xfer(input logic [0:2] f);
        return ~f[1];
    endfunction

    function automatic logic cmd_is_write(input logic [0:2] f);
        return f[0] & ~f[1];
    endfunction

endpackage

// File: rtl/rk_ctrl_gen_if.sv
// rtl/rk_ctrl_gen_if.sv - controller <-> sd SPI block link
// Signals: sd_op (command), sd_state (sdSTAT.state), sd_dma_addr (final DMA
// address), sd_mem_addr, sd_disk_addr, sd_len.
// Modports: master = controller side, slave = sd side.
interface rk_ctrl_gen_if;
    import sd_types::*;

    sdOP_t       sd_op;
    sdSTATE_t    sd_state;
    logic [0:14] sd_dma_addr;
    logic [0:14] sd_mem_addr;
    sdDISKaddr_t sd_disk_addr;
    logic        sd_len;

    modport master (
        output sd_op, sd_mem_addr, sd_disk_addr, sd_len,
        input  sd_state, sd_dma_addr
    );

    modport slave (
        input  sd_op, sd_mem_addr, sd_disk_addr, sd_len,
        output sd_state, sd_dma_addr
    );

endinterface

// File: rtl/rk_ctrl_gen_iot_decode.sv
// rtl/rk_ctrl_gen_iot_decode.sv - IOT decode into a one-hot function strobe
// Ports: instruction, state (CPU major state), uf (user mode) in;
// fn[7:0] one-hot strobe indexed by instruction[9:11], caf (6007) out.
module rk_iot_decode
    import sd_types::*;
#(
    parameter logic [5:0] DEVCODE = 6'o74
) (
    input  logic [0:11] instruction,
    input  logic [4:0]  state,
    input  logic        uf,
    output logic [7:0]  fn,
    output logic        caf
);

    logic iot;

    always_comb begin
        iot = (state == CPU_F1) && !uf && (instruction[0:2] == 3'o6);
        fn  = '0;
        if (iot && (instruction[3:8] == DEVCODE)) begin
            fn[instruction[9:11]] = 1'b1;
        end
        caf = iot && (instruction[3:11] == 9'o007);
    end

endmodule

// File: rtl/rk_ctrl_gen.sv
// rtl/rk_ctrl_gen.sv - RK8E-class disk controller front-end (IOT regs + sd sequencer)
// Ports: clk, reset (sync, active-high), clear (IOCLR), instruction, state,
// ac, UF in; disk_bus, skip, interrupt, to_disk out; sd (rk_ctrl_gen_if.master).
// Parameters: DEVCODE, NDRIVES (1..4), MAX_CYL.
// Build option: RK_DMAN_EN enables DMAN (function 7) register readback.
module rk_ctrl_gen
    import sd_types::*;
#(
    parameter logic [5:0] DEVCODE = 6'o74,
    parameter int         NDRIVES = 4,
    parameter int         MAX_CYL = 202
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [0:11]   instruction,
    input  logic [4:0]    state,
    input  logic [0:11]   ac,
    input  logic          UF,
    output logic [0:11]   disk_bus,
    output logic          skip,
    output logic          interrupt,
    output logic          to_disk,
    rk_ctrl_gen_if.master sd
);

    logic [7:0]  fn;
    logic        caf;

    logic [0:11] cmd_reg;
    logic [0:11] car;
    logic [0:11] dar;
    logic [0:11] status;
    logic [3:0]  wlock;
    logic        seek_pend;
    logic        xfer_wr;

    rkFSM_t      fsm;
    rkFSM_t      fsm_next;
    sdOP_t       op_c;
    logic        xfer_done;
    logic        xfer_fail;

    logic        clr_any;
    logic [1:0]  drive;
    logic [7:0]  cyl;
    logic [0:11] dlag_err;
    logic        dlag_ok;
    logic        start;
    logic        seek_set;
    logic        abort_req;

    rk_iot_decode #(.DEVCODE(DEVCODE)) u_decode (
        .instruction (instruction),
        .state       (state),
        .uf          (UF),
        .fn          (fn),
        .caf         (caf)
    );

    assign clr_any = clear | caf;
    assign drive   = cmd_reg[9:10];
    assign cyl     = {cmd_reg[11], ac[0:6]};

    // DLAG validation; only the first failing check is reported
    always_comb begin
        dlag_err = '0;
        if (fsm != rkIDLE) begin
            dlag_err[STAT_BUSY] = 1'b1;
        end else if (32'(drive) >= NDRIVES) begin
            dlag_err[STAT_DRIVE] = 1'b1;
        end else if (32'(cyl) > MAX_CYL) begin
            dlag_err[STAT_CYL] = 1'b1;
        end else if (cmd_is_write(cmd_reg[0:2]) && wlock[drive]) begin
            dlag_err[STAT_WLOCK] = 1'b1;
        end
    end

    assign dlag_ok  = fn[FN_DLAG] && (dlag_err == '0);
    assign start    = dlag_ok && cmd_is_xfer(cmd_reg[0:2]);
    // Seek reports done only when asked to; NOP (11x) always does
    assign seek_set = dlag_ok &&
                      (((cmd_reg[0:2] == CMD_SEEK) && cmd_reg[4]) ||
                       (cmd_reg[0:1] == 2'b11));
    assign abort_req = (clr_any || (fn[FN_DCLC] && ac[11])) && (fsm != rkIDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= rkIDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Commands are held only while sd still reports READY, so sd sees a
    // level it can sample and drop once it has accepted the request.
    always_comb begin
        fsm_next  = fsm;
        op_c      = sdopNOP;
        xfer_done = 1'b0;
        xfer_fail = 1'b0;
        case (fsm)
            rkIDLE: begin
                if (start) begin
                    fsm_next = rkISSUE;
                end
            end
            rkISSUE: begin
                if (sd.sd_state == sdstateREADY) begin
                    op_c = xfer_wr ? sdopWR : sdopRD;
                end else begin
                    fsm_next = rkXFER;
                end
            end
            rkXFER: begin
                if (sd.sd_state == sdstateDONE) begin
                    xfer_done = 1'b1;
                    fsm_next  = rkIDLE;
                end else if ((sd.sd_state == sdstateINFAIL) ||
                             (sd.sd_state == sdstateRWFAIL)) begin
                    xfer_fail = 1'b1;
                    fsm_next  = rkIDLE;
                end
            end
            rkABORT: begin
                if (sd.sd_state == sdstateREADY) begin
                    fsm_next = rkIDLE;
                end else begin
                    op_c = sdopABORT;
                end
            end
            default: fsm_next = rkIDLE;
        endcase
        if (abort_req) begin
            fsm_next  = rkABORT;
            xfer_done = 1'b0;
            xfer_fail = 1'b0;
        end
    end

    // Sequencer results are applied first so that a same-cycle IOT write
    // to the same register overrides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg   <= '0;
            car       <= '0;
            dar       <= '0;
            status    <= '0;
            wlock     <= '0;
            seek_pend <= 1'b0;
            xfer_wr   <= 1'b0;
            disk_bus  <= '0;
            skip      <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            interrupt <= (status != '0) && cmd_reg[3];
            seek_pend <= seek_set;

            if (state == CPU_F1) begin
                skip <= fn[FN_DSKP] && (status != '0);
            end

            if (seek_pend) begin
                status[STAT_DONE] <= 1'b1;
            end
            if (xfer_done) begin
                status[STAT_DONE] <= 1'b1;
                car               <= sd.sd_dma_addr[3:14];
                cmd_reg[6:8]      <= sd.sd_dma_addr[0:2];
            end
            if (xfer_fail) begin
                status[STAT_DRIVE] <= 1'b1;
            end
            if (start) begin
                xfer_wr <= cmd_is_write(cmd_reg[0:2]);
            end

            if (fn[FN_DCLC]) begin
                status <= '0;
            end
            if (fn[FN_DLAG]) begin
                dar <= ac;
                for (int i = 0; i < 12; i++) begin
                    if (dlag_err[i]) begin
                        status[i] <= 1'b1;
                    end
                end
            end
            if (fn[FN_DLCA]) begin
                car <= ac;
            end
            if (fn[FN_DRST]) begin
                disk_bus <= status;
            end
            if (fn[FN_DLDC]) begin
                cmd_reg <= ac;
                status  <= '0;
                if (ac[0:2] == CMD_WPROT) begin
                    wlock[ac[9:10]] <= 1'b1;
                end
            end
`ifdef RK_DMAN_EN
            if (fn[FN_DMAN]) begin
                disk_bus <= ac[0] ? dar : car;
            end
`endif

            // Write locks model per-drive hardware state and survive IOCLR
            if (clr_any) begin
                cmd_reg   <= '0;
                car       <= '0;
                dar       <= '0;
                status    <= '0;
                seek_pend <= 1'b0;
            end
        end
    end

    logic unused_fn;
`ifdef RK_DMAN_EN
    assign unused_fn = fn[0];
`else
    assign unused_fn = fn[0] ^ fn[FN_DMAN];
`endif

    assign to_disk         = xfer_wr;
    assign sd.sd_op        = op_c;
    assign sd.sd_mem_addr  = {cmd_reg[6:8], car};
    assign sd.sd_disk_addr = {17'd0, cmd_reg[9:10], cmd_reg[11], dar};
    assign sd.sd_len       = cmd_reg[5];

endmodule

// File: tb/tb_rk_ctrl_gen.sv
// tb/tb_rk_ctrl_gen.sv - self-checking bench for rk_ctrl_gen
module tb_rk_ctrl_gen;
    import sd_types::*;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [0:11] instruction;
    logic [4:0]  cpu_state;
    logic [0:11] ac;
    logic        uf;
    logic [0:11] disk_bus;
    logic        skip;
    logic        interrupt;
    logic        to_disk;

    rk_ctrl_gen_if sd_if ();

    rk_ctrl_gen #(.NDRIVES(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .instruction (instruction),
        .state       (cpu_state),
        .ac          (ac),
        .UF          (uf),
        .disk_bus    (disk_bus),
        .skip        (skip),
        .interrupt   (interrupt),
        .to_disk     (to_disk),
        .sd          (sd_if)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [0:11] a;
        logic [0:11] st;
        logic [0:14] mem;
        logic [0:11] dar;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0o required=%0o", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raw(input logic [0:11] ins, input logic [0:11] a);
        instruction = ins;
        ac          = a;
        cpu_state   = CPU_F1;
        @(negedge clk);
        cpu_state   = 5'd0;
        instruction = 12'o0000;
    endtask

    task automatic iot(input logic [2:0] f, input logic [0:11] a);
        raw({3'o6, 6'o74, f}, a);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; instruction = '0; cpu_state = '0;
        ac = '0; uf = 1'b0;
        sd_if.sd_state = sdstateREADY;
        sd_if.sd_dma_addr = '0;

        tbl[0]  = '{FN_DLDC, 12'o2000, 12'o0000, 15'o00000, 12'o0000};
        tbl[1]  = '{FN_DLDC, 12'o4000, 12'o0000, 15'o00000, 12'o0000};
        tbl[2]  = '{FN_DLAG, 12'o0000, 12'o0020, 15'o00000, 12'o0000};
        tbl[3]  = '{FN_DLCA, 12'o1234, 12'o0020, 15'o01234, 12'o0000};
        tbl[4]  = '{FN_DLDC, 12'o0001, 12'o0000, 15'o01234, 12'o0000};
        tbl[5]  = '{FN_DLAG, 12'o4540, 12'o0001, 15'o01234, 12'o4540};
        tbl[6]  = '{FN_DLDC, 12'o3201, 12'o0000, 15'o01234, 12'o4540};
        tbl[7]  = '{FN_DLAG, 12'o4500, 12'o4000, 15'o01234, 12'o4500};
        tbl[8]  = '{FN_DLDC, 12'o3001, 12'o0000, 15'o01234, 12'o4500};
        tbl[9]  = '{FN_DLAG, 12'o0100, 12'o0000, 15'o01234, 12'o0100};
        tbl[10] = '{FN_DLDC, 12'o0002, 12'o0000, 15'o01234, 12'o0100};
        tbl[11] = '{FN_DLAG, 12'o0000, 12'o0002, 15'o01234, 12'o0000};
        tbl[12] = '{FN_DCLC, 12'o0000, 12'o0000, 15'o01234, 12'o0000};
        tbl[13] = '{FN_DLDC, 12'o6000, 12'o0000, 15'o01234, 12'o0000};
        tbl[14] = '{FN_DLAG, 12'o0000, 12'o4000, 15'o01234, 12'o0000};
        tbl[15] = '{FN_DLDC, 12'o0050, 12'o0000, 15'o51234, 12'o0000};

        tick(3);
        reset = 1'b0;
        chk("rst_disk_bus", disk_bus, 0);
        chk("rst_skip", skip, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_to_disk", to_disk, 0);
        chk("rst_op", sd_if.sd_op, sdopNOP);
        chk("rst_mem", sd_if.sd_mem_addr, 0);
        iot(FN_DSKP, 12'o0000);
        chk("dskp_zero", skip, 0);

        // Plain read with field carry
        iot(FN_DLDC, 12'o0000);
        iot(FN_DLCA, 12'o0200);
        iot(FN_DLAG, 12'o0010);
        chk("rd_op_issue", sd_if.sd_op, sdopRD);
        chk("rd_to_disk", to_disk, 0);
        chk("rd_daddr", sd_if.sd_disk_addr, 32'o10);
        sd_if.sd_state = sdstateREAD;
        tick(1);
        chk("rd_op_xfer", sd_if.sd_op, sdopNOP);
        sd_if.sd_dma_addr = 15'o10400;
        sd_if.sd_state = sdstateDONE;
        tick(1);
        sd_if.sd_state = sdstateREADY;
        chk("rd_mem_carry", sd_if.sd_mem_addr, 15'o10400);
        iot(FN_DRST, 12'o0000);
        chk("rd_status", disk_bus, 12'o4000);
        chk("rd_irq_off", interrupt, 0);

        // Busy DLAG during a transfer, interrupt latency
        iot(FN_DLDC, 12'o0400);
        iot(FN_DLAG, 12'o0020);
        chk("busy_op_issue", sd_if.sd_op, sdopRD);
        sd_if.sd_state = sdstateREAD;
        tick(1);
        iot(FN_DLAG, 12'o0077);
        chk("busy_irq_early", interrupt, 0);
        tick(1);
        chk("busy_irq", interrupt, 1);
        chk("busy_op_xfer", sd_if.sd_op, sdopNOP);
        sd_if.sd_dma_addr = 15'o20030;
        sd_if.sd_state = sdstateDONE;
        tick(1);
        sd_if.sd_state = sdstateREADY;
        iot(FN_DRST, 12'o0000);
        chk("busy_status", disk_bus, 12'o4100);
        chk("busy_mem", sd_if.sd_mem_addr, 15'o20030);
        iot(FN_DCLC, 12'o0000);
        tick(1);
        chk("dclc_irq_drop", interrupt, 0);

        // Write, abort via DCLC ac[11], then a failed write
        iot(FN_DLDC, 12'o4000);
        iot(FN_DLAG, 12'o0005);
        chk("wr_op_issue", sd_if.sd_op, sdopWR);
        chk("wr_to_disk", to_disk, 1);
        sd_if.sd_state = sdstateWRITE;
        tick(1);
        iot(FN_DCLC, 12'o0001);
        chk("abort_op", sd_if.sd_op, sdopABORT);
        tick(1);
        chk("abort_op_hold", sd_if.sd_op, sdopABORT);
        sd_if.sd_state = sdstateREADY;
        tick(1);
        chk("abort_op_done", sd_if.sd_op, sdopNOP);
        iot(FN_DLAG, 12'o0006);
        chk("after_abort_idle", sd_if.sd_op, sdopWR);
        sd_if.sd_state = sdstateWRITE;
        tick(1);
        sd_if.sd_state = sdstateRWFAIL;
        tick(1);
        sd_if.sd_state = sdstateREADY;
        iot(FN_DRST, 12'o0000);
        chk("fail_status", disk_bus, 12'o0002);
        chk("fail_op", sd_if.sd_op, sdopNOP);

        // CAF during a transfer
        iot(FN_DLDC, 12'o0000);
        iot(FN_DLCA, 12'o0555);
        chk("caf_mem_pre", sd_if.sd_mem_addr, 15'o00555);
        iot(FN_DLAG, 12'o0001);
        sd_if.sd_state = sdstateREAD;
        tick(1);
        raw(12'o6007, 12'o0000);
        chk("caf_op", sd_if.sd_op, sdopABORT);
        chk("caf_mem_zero", sd_if.sd_mem_addr, 0);
        sd_if.sd_state = sdstateREADY;
        tick(1);
        chk("caf_op_done", sd_if.sd_op, sdopNOP);

        uf = 1'b1;
        iot(FN_DLCA, 12'o7777);
        uf = 1'b0;
        chk("uf_ignored", sd_if.sd_mem_addr, 0);

        // Register/validation vectors
        for (int i = 0; i < 16; i++) begin
            iot(tbl[i].f, tbl[i].a);
            tick(2);
            iot(FN_DRST, 12'o0000);
            chk($sformatf("r%0d_status", i), disk_bus, tbl[i].st);
            chk($sformatf("r%0d_mem", i), sd_if.sd_mem_addr, tbl[i].mem);
            chk($sformatf("r%0d_dar", i), sd_if.sd_disk_addr[20:31], tbl[i].dar);
            chk($sformatf("r%0d_op", i), sd_if.sd_op, sdopNOP);
        end

        // Seek with done-on-seek: status lands one cycle after DLAG
        iot(FN_DLDC, 12'o3200);
        iot(FN_DLAG, 12'o0123);
        chk("seek_op", sd_if.sd_op, sdopNOP);
        iot(FN_DSKP, 12'o0000);
        chk("seek_skip_early", skip, 0);
        iot(FN_DSKP, 12'o0000);
        chk("seek_skip", skip, 1);
        iot(FN_DRST, 12'o0000);
        chk("skip_clear_f1", skip, 0);
        chk("seek_status", disk_bus, 12'o4000);
        iot(FN_DMAN, 12'o4000);
`ifdef RK_DMAN_EN
        chk("dman_dar", disk_bus, 12'o0123);
`else
        chk("dman_noop", disk_bus, 12'o4000);
`endif
        iot(FN_DMAN, 12'o0000);
`ifdef RK_DMAN_EN
        chk("dman_car", disk_bus, 12'o1234);
`else
        chk("dman_noop2", disk_bus, 12'o4000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
